// File: rtl/sd4_mac_pkg.sv
// Shared defaults and helpers for the SD4 MAC / block-floating-point datapath.
package sd4_mac_pkg;

  localparam int LANES_DEF     = 9;
  localparam int MANT_W_DEF    = 5;
  localparam int EXP_W_DEF     = 5;
  localparam int FRAC_W_DEF    = 11;
  localparam int ACC_GUARD_DEF = 4;
  localparam int ALIGN_W_DEF   = MANT_W_DEF + FRAC_W_DEF;
  localparam int SUM_W_DEF     = ALIGN_W_DEF + $clog2(LANES_DEF);
  localparam int ACC_W_DEF     = SUM_W_DEF + ACC_GUARD_DEF;

  typedef enum logic {
    FRAME_IDLE = 1'b0,
    FRAME_BUSY = 1'b1
  } frame_e;

  // An arithmetic shift of a w-bit value by w-1 already gives 0 or -1,
  // so clamping the amount there implements the shift-out rule exactly.
  function automatic int unsigned sat_shamt(input int unsigned sh, input int unsigned w);
    return (sh >= w) ? (w - 1) : sh;
  endfunction

endpackage

// File: rtl/bfp_dot_accumulator_if.sv
// Beat-in / frame-out handshake bundle of the BFP dot accumulator.
interface bfp_dot_accumulator_if #(
  parameter int LANES     = sd4_mac_pkg::LANES_DEF,
  parameter int MANT_W    = sd4_mac_pkg::MANT_W_DEF,
  parameter int EXP_W     = sd4_mac_pkg::EXP_W_DEF,
  parameter int FRAC_W    = sd4_mac_pkg::FRAC_W_DEF,
  parameter int ACC_GUARD = sd4_mac_pkg::ACC_GUARD_DEF
);
  localparam int ACC_W = MANT_W + FRAC_W + $clog2(LANES) + ACC_GUARD;

  logic                      in_valid;
  logic                      in_ready;
  logic                      in_last;
  logic [LANES*MANT_W-1:0]   in_pp;
  logic [LANES*EXP_W-1:0]    in_exp;
  logic [EXP_W-1:0]          in_exp_bias;
  logic                      out_valid;
  logic                      out_ready;
  logic [ACC_W-1:0]          out_sum;
  logic [EXP_W:0]            out_exp;
  logic [7:0]                out_beats;

  modport master (
    output in_valid, in_last, in_pp, in_exp, in_exp_bias, out_ready,
    input  in_ready, out_valid, out_sum, out_exp, out_beats
  );

  modport slave (
    input  in_valid, in_last, in_pp, in_exp, in_exp_bias, out_ready,
    output in_ready, out_valid, out_sum, out_exp, out_beats
  );
endinterface

// File: rtl/bfp_lane_align.sv
// One lane: widen a signed partial product by FRAC_W fraction bits and
// arithmetically right-shift it onto the beat's common exponent.
module bfp_lane_align
  import sd4_mac_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W  = EXP_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic        [MANT_W-1:0]        pp,
  input  logic        [EXP_W-1:0]         shamt,
  output logic signed [MANT_W+FRAC_W-1:0] aligned
);
  localparam int ALIGN_W = MANT_W + FRAC_W;

  logic signed [ALIGN_W-1:0] base;

  assign base    = {pp, {FRAC_W{1'b0}}};
  assign aligned = base >>> sat_shamt(32'(shamt), ALIGN_W);
endmodule

// File: rtl/bfp_dot_accumulator.sv
// Three-stage align/sum pipeline followed by a block-floating-point frame
// accumulator; one beat per cycle, whole pipeline freezes on output stall.
module bfp_dot_accumulator
  import sd4_mac_pkg::*;
#(
  parameter int LANES     = LANES_DEF,
  parameter int MANT_W    = MANT_W_DEF,
  parameter int EXP_W     = EXP_W_DEF,
  parameter int FRAC_W    = FRAC_W_DEF,
  parameter int ACC_GUARD = ACC_GUARD_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  bfp_dot_accumulator_if.slave bus
);
  localparam int ALIGN_W = MANT_W + FRAC_W;
  localparam int LOG_L   = $clog2(LANES);
  localparam int SUM_W   = ALIGN_W + LOG_L;
  localparam int ACC_W   = SUM_W + ACC_GUARD;

  logic stall, accept, out_valid_q;
  assign stall        = out_valid_q & ~bus.out_ready;
  assign bus.in_ready = ~stall;
  assign accept       = bus.in_valid & ~stall;

  // S1
  logic                    v1, last1;
  logic [EXP_W-1:0]        bias1;
  logic [LANES*MANT_W-1:0] pp1;
  logic [LANES*EXP_W-1:0]  exp1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; last1 <= 1'b0; bias1 <= '0; pp1 <= '0; exp1 <= '0;
    end else if (!stall) begin
      v1 <= accept; last1 <= bus.in_last; bias1 <= bus.in_exp_bias;
      pp1 <= bus.in_pp; exp1 <= bus.in_exp;
    end
  end

  // S2: max exponent tree, per-lane alignment
  logic        [EXP_W-1:0]   exp_lane [LANES];
  logic signed [ALIGN_W-1:0] aligned  [LANES];
  logic        [EXP_W-1:0]   emax;

  for (genvar l = 0; l <= LOG_L; l++) begin : g_max
    logic [EXP_W-1:0] node [2**(LOG_L-l)];
    for (genvar n = 0; n < 2**(LOG_L-l); n++) begin : g_n
      if (l == 0) begin : g_leaf
        if (n < LANES) begin : g_in
          assign node[n] = exp_lane[n];
        end else begin : g_pad
          assign node[n] = '0;
        end
      end else begin : g_cmp
        assign node[n] = (g_max[l-1].node[2*n] > g_max[l-1].node[2*n+1]) ?
                         g_max[l-1].node[2*n] : g_max[l-1].node[2*n+1];
      end
    end
  end
  assign emax = g_max[LOG_L].node[0];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign exp_lane[i] = exp1[(LANES-1-i)*EXP_W +: EXP_W];
    bfp_lane_align #(.MANT_W(MANT_W), .EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_align (
      .pp      (pp1[(LANES-1-i)*MANT_W +: MANT_W]),
      .shamt   (emax - exp_lane[i]),
      .aligned (aligned[i])
    );
  end

  logic                      v2, last2;
  logic        [EXP_W-1:0]   bias2, emax2;
  logic signed [ALIGN_W-1:0] aligned2 [LANES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b0; last2 <= 1'b0; bias2 <= '0; emax2 <= '0;
      for (int unsigned i = 0; i < LANES; i++) aligned2[i] <= '0;
    end else if (!stall) begin
      v2 <= v1; last2 <= last1; bias2 <= bias1; emax2 <= emax;
      for (int unsigned i = 0; i < LANES; i++) aligned2[i] <= aligned[i];
    end
  end

  // S3: signed adder tree, padded to a power of two with zero leaves
  logic signed [SUM_W-1:0] sum;

  for (genvar l = 0; l <= LOG_L; l++) begin : g_add
    logic signed [SUM_W-1:0] node [2**(LOG_L-l)];
    for (genvar n = 0; n < 2**(LOG_L-l); n++) begin : g_n
      if (l == 0) begin : g_leaf
        if (n < LANES) begin : g_in
          assign node[n] = {{(SUM_W-ALIGN_W){aligned2[n][ALIGN_W-1]}}, aligned2[n]};
        end else begin : g_pad
          assign node[n] = '0;
        end
      end else begin : g_sum
        assign node[n] = g_add[l-1].node[2*n] + g_add[l-1].node[2*n+1];
      end
    end
  end
  assign sum = g_add[LOG_L].node[0];

  logic                    v3, last3;
  logic [EXP_W-1:0]        bias3, emax3;
  logic signed [SUM_W-1:0] sum3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3 <= 1'b0; last3 <= 1'b0; bias3 <= '0; emax3 <= '0; sum3 <= '0;
    end else if (!stall) begin
      v3 <= v2; last3 <= last2; bias3 <= bias2; emax3 <= emax2; sum3 <= sum;
    end
  end

  // S4: BFP accumulator; the smaller-exponent operand is the one shifted
  frame_e                  acc_phase;
  logic signed [ACC_W-1:0] acc, acc_new, sum_ext;
  logic [EXP_W-1:0]        acc_exp, acc_exp_new;
  logic [7:0]              cnt, cnt_new;
  logic [ACC_W-1:0]        out_sum_q;
  logic [EXP_W:0]          out_exp_q;
  logic [7:0]              out_beats_q;

  assign sum_ext = {{ACC_GUARD{sum3[SUM_W-1]}}, sum3};

  always_comb begin
    acc_new     = sum_ext;
    acc_exp_new = emax3;
    cnt_new     = 8'd1;
    if (acc_phase == FRAME_BUSY) begin
      cnt_new = (cnt == 8'hFF) ? 8'hFF : cnt + 8'd1;
      if (emax3 > acc_exp) begin
        acc_new = (acc >>> sat_shamt(32'(emax3 - acc_exp), ACC_W)) + sum_ext;
      end else begin
        acc_new     = acc + (sum_ext >>> sat_shamt(32'(acc_exp - emax3), ACC_W));
        acc_exp_new = acc_exp;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0; acc_exp <= '0; cnt <= '0; acc_phase <= FRAME_IDLE;
      out_valid_q <= 1'b0; out_sum_q <= '0; out_exp_q <= '0; out_beats_q <= '0;
    end else if (!stall) begin
      if (v3) begin
        acc       <= acc_new;
        acc_exp   <= acc_exp_new;
        cnt       <= cnt_new;
        acc_phase <= last3 ? FRAME_IDLE : FRAME_BUSY;
      end
      out_valid_q <= v3 & last3;
      if (v3 && last3) begin
        out_sum_q   <= acc_new;
        out_exp_q   <= {1'b0, acc_exp_new} + {1'b0, bias3};
        out_beats_q <= cnt_new;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_exp   = out_exp_q;
  assign bus.out_beats = out_beats_q;
endmodule

// File: doc/bfp_dot_accumulator.md
# bfp_dot_accumulator

Parametrised successor to the fixed nine-lane SD4 MAC datapath. Takes one beat of `LANES` signed partial products with per-lane exponents, finds the beat's maximum exponent, aligns and sums the lanes in a three-stage pipeline, and accumulates consecutive beats of a frame in block-floating-point form, rescaling across beats. Sits between the partial-product generators and the normalization/subnormal stage, with valid/ready handshakes on both sides.

## Interface
- `LANES`, 9: lanes per beat (≥2)
- `MANT_W`, 5: signed partial-product width
- `EXP_W`, 5: unsigned exponent width
- `FRAC_W`, 11: fractional bits added on alignment; `ALIGN_W = MANT_W+FRAC_W`
- `ACC_GUARD`, 4: extra accumulator bits; `SUM_W = ALIGN_W+$clog2(LANES)`, `ACC_W = SUM_W+ACC_GUARD`
- `clk  in  1  clock, rising edge`
- `rst  in  1  reset; asynchronous, active-high`
- `in_valid  in  1  beat present`
- `in_ready  out  1  beat accepted when in_valid & in_ready`
- `in_last  in  1  final beat of frame`
- `in_pp  in  LANES*MANT_W  signed mantissas, lane 0 in MSBs`
- `in_exp  in  LANES*EXP_W  exponents, lane 0 in MSBs`
- `in_exp_bias  in  EXP_W  bias; sampled only on the last beat`
- `out_valid  out  1  frame result held`
- `out_ready  in  1  consumer accepts result`
- `out_sum  out  ACC_W  signed accumulated sum, FRAC_W fractional bits`
- `out_exp  out  EXP_W+1  final exponent + bias, unsigned, no wrap`
- `out_beats  out  8  beats in frame, saturating at 255`

## Operation
- S1: accepted beat, `in_last` and `in_exp_bias` registered.
- S2: `exp_max` = max of the lane exponents. Each lane is sign-extended to `ALIGN_W`, shifted left by `FRAC_W`, then arithmetically right-shifted by `exp_max − exp`. Shifts ≥ `ALIGN_W` yield 0 for a positive lane and −1 for a negative lane. Truncation is toward −∞. Registered with `exp_max`.
- S3: signed adder tree of aligned lanes into `SUM_W`, with no overflow possible. Registered with `exp_max`.
- S4 accumulator (`acc`, `acc_exp`, `acc_busy`, beat count):
  - First beat of a frame (`acc_busy=0`): `acc = sext(sum)`, `acc_exp = exp_max`.
  - Otherwise, if `exp_max > acc_exp`: `acc = (acc >>> d) + sext(sum)`, `acc_exp = exp_max`, where `d` is the exponent difference.
  - Otherwise: `acc = acc + (sext(sum) >>> d)`.
  - Same shift-out rule as S2. `acc` wraps in two's complement if more than 2^`ACC_GUARD` full-scale beats are summed.
- On a last beat, the output register loads the merged `acc`, `out_exp = acc_exp_new + bias`, and `out_beats`. `acc_busy` clears, and a new frame may start on the next beat with no bubble.
- Non-last beats produce no output.

## Timing
- Reset values: all pipeline valids, `acc`, `acc_exp`, `acc_busy`, count, `out_valid`, `out_sum`, `out_exp`, `out_beats` = 0; `in_ready` = 1.
- `stall = out_valid & ~out_ready`. `in_ready = ~stall` (combinational). Every stage register and the accumulator hold while stalled, so no beat is lost or duplicated.
- Latency: a last beat accepted at edge e0 gives `out_valid` high after edge e3. Throughput is one beat per cycle when unstalled.
- Output holds stable while `out_valid & ~out_ready`. `out_valid` clears on handshake unless a new result loads on the same edge, in which case it stays 1 with the new data.
- The accumulator merges on every S3 valid beat when not stalled. Bubbles (no S3 valid) leave it unchanged.
- `rst` mid-frame discards the partial frame and all in-flight beats. The next accepted beat starts a new frame.
- Bias max plus exponent max (31+31=62) fits `EXP_W+1`.

## Structure
- Shared package `sd4_mac_pkg`:
  - default `LANES`, `MANT_W`, `EXP_W`, `FRAC_W`, `ACC_GUARD`
  - derived `ALIGN_W`, `SUM_W`, `ACC_W`
  - a saturating-shift arithmetic helper function
- One sub-module `bfp_lane_align` (one lane, combinational shift/sign-fill), instantiated `LANES` times via generate.
- The max-exponent reduction and adder tree stay inline as generate loops.

## Test plan
- All lanes pp=+1, exp=3, bias=0, last=1 → `out_sum`=18432, `out_exp`=3, `out_beats`=1, `out_valid` 3 cycles after accept.
- Lane0 pp=+1 exp=4, lane1 pp=+1 exp=2, rest pp=0 exp=0, bias=7 → `out_sum`=2560, `out_exp`=11. Lane0 pp=−2 exp=5, rest pp=0 → −4096, `out_exp`=5+bias.
- Lane0 pp=+1 exp=31, lane1 pp=−1 exp=0, rest pp=0 → `out_sum`=2047 (shift-out gives −1), `out_exp`=31.
- Two-beat frame: beat A lane0 pp=+1 exp=2; beat B lane0 pp=+1 exp=3, last, bias 0 → `out_sum`=3072, `out_exp`=3, `out_beats`=2. Reverse exponent order → also 3072/3. Back-to-back frames give no bubble.
- `out_ready`=0 for 10 cycles with 3 frames streaming → `in_ready`=0, output stable, all 3 results emerge in order after release.
- `rst` pulsed after first beat of a frame → outputs zero; following single-beat frame reports `out_beats`=1 with no residue.
